// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master TX slice: FSM encoding, SPI mode and default sizing.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCsSetup = 2'd1,
        StShift   = 2'd2,
        StCsHold  = 2'd3
    } spi_state_e;

    // Mode 0 only: SCLK idles low, data launched on falling edge, sampled on rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_CLK_DIV    = 4;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for SCLK: one-cycle half_tick every CLK_DIV enabled cycles.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic half_tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Held at zero while disabled so every transaction starts on a full half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign half_tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master serializer, MSB first, one word per valid/ready handshake.
// Define SPI_MASTER_RX_EN to add MISO capture (full duplex).
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_tx_data_valid,
    input  logic [DATA_WIDTH-1:0] spi_tx_data,
    output logic                  spi_tx_ready,
    output logic                  spi_busy,
    output logic                  spi_cs_n,
    output logic                  spi_sclk,
    output logic                  spi_mosi
`ifdef SPI_MASTER_RX_EN
    ,
    input  logic                  spi_miso,
    output logic [DATA_WIDTH-1:0] spi_rx_data,
    output logic                  spi_rx_data_valid
`endif
);

    localparam int unsigned BIT_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_HALF = BIT_W'(2 * DATA_WIDTH - 1);

    spi_state_e            state;
    logic [DATA_WIDTH-1:0] tx_shreg;
    logic [BIT_W-1:0]      half_cnt;
    logic                  half_tick;
    logic                  div_en;

    assign div_en = (state != StIdle);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (div_en),
        .half_tick(half_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            spi_tx_ready <= 1'b0;
            spi_busy     <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_sclk     <= CPOL;
            spi_mosi     <= 1'b0;
            tx_shreg     <= '0;
            half_cnt     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    spi_cs_n <= 1'b1;
                    spi_sclk <= CPOL;
                    spi_busy <= 1'b0;
                    half_cnt <= '0;
                    if (spi_tx_data_valid && spi_tx_ready) begin
                        tx_shreg     <= spi_tx_data;
                        spi_mosi     <= spi_tx_data[DATA_WIDTH-1];
                        spi_cs_n     <= 1'b0;
                        spi_tx_ready <= 1'b0;
                        spi_busy     <= 1'b1;
                        state        <= StCsSetup;
                    end else begin
                        spi_tx_ready <= 1'b1;
                    end
                end
                StCsSetup: begin
                    if (half_tick) begin
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (half_tick) begin
                        half_cnt <= half_cnt + 1'b1;
                        if (half_cnt == LAST_HALF) begin
                            // Final falling edge: no further bit, MOSI keeps the LSB.
                            spi_sclk <= CPOL;
                            state    <= StCsHold;
                        end else begin
                            spi_sclk <= ~spi_sclk;
                            if (spi_sclk) begin
                                tx_shreg <= tx_shreg << 1;
                                spi_mosi <= tx_shreg[DATA_WIDTH-2];
                            end
                        end
                    end
                end
                StCsHold: begin
                    if (half_tick) begin
                        spi_cs_n     <= 1'b1;
                        spi_tx_ready <= 1'b1;
                        spi_busy     <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SPI_MASTER_RX_EN
    logic [DATA_WIDTH-1:0] rx_shreg;

    // MISO is captured on the same clk edge that raises SCLK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shreg          <= '0;
            spi_rx_data       <= '0;
            spi_rx_data_valid <= 1'b0;
        end else begin
            spi_rx_data_valid <= 1'b0;
            if (state == StShift && half_tick && !spi_sclk) begin
                rx_shreg <= {rx_shreg[DATA_WIDTH-2:0], spi_miso};
            end
            if (state == StCsHold && half_tick) begin
                spi_rx_data       <= rx_shreg;
                spi_rx_data_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: random and directed words, monitor decodes the SPI pins.
module tb_spi_master_tx;

    localparam int W = 8;
`ifdef SPI_MASTER_RX_EN
    localparam int D = 1;
`else
    localparam int D = 2;
`endif
    localparam int READY_LOW = (2 * W + 2) * D;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] data  = '0;
    logic         ready, busy, cs_n, sclk, mosi;
`ifdef SPI_MASTER_RX_EN
    logic [W-1:0] rx_data;
    logic         rx_valid;
`endif

    always #5 clk = ~clk;

    spi_master_tx #(
        .DATA_WIDTH(W),
        .CLK_DIV   (D)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .spi_tx_data_valid(valid),
        .spi_tx_data      (data),
        .spi_tx_ready     (ready),
        .spi_busy         (busy),
        .spi_cs_n         (cs_n),
        .spi_sclk         (sclk),
        .spi_mosi         (mosi)
`ifdef SPI_MASTER_RX_EN
        ,
        .spi_miso         (mosi),
        .spi_rx_data      (rx_data),
        .spi_rx_data_valid(rx_valid)
`endif
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: rebuilds each word from MOSI at SCLK rising edges, checks on CS_N release.
    logic         prev_sclk = 1'b0;
    logic         prev_cs_n = 1'b1;
    logic [W-1:0] bit_word  = '0;
    logic [W-1:0] exp_word;
    int           rise_cnt  = 0;
    int           hi_cnt    = 0;
    int           low_cnt   = 0;
    bit           acc_seen  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            acc_seen  = 1'b0;
            bit_word  = '0;
            rise_cnt  = 0;
            hi_cnt    = 0;
            prev_sclk = sclk;
            prev_cs_n = cs_n;
        end else begin
            if (acc_seen && ready) begin
                check("ready_low_cycles", low_cnt, READY_LOW);
                acc_seen = 1'b0;
            end else if (acc_seen) begin
                low_cnt++;
            end
            if (valid && ready) begin
                acc_seen = 1'b1;
                low_cnt  = 0;
            end

            if (sclk && !prev_sclk) begin
                check("cs_low_at_rise", cs_n, 0);
                bit_word = {bit_word[W-2:0], mosi};
                rise_cnt++;
            end
            if (!cs_n && prev_cs_n) begin
                check("cs_high_gap", hi_cnt >= 1, 1);
                bit_word = '0;
                rise_cnt = 0;
            end
            if (cs_n && !prev_cs_n) begin
                check("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    exp_word = sb_q.pop_front();
                    check("tx_word", bit_word, exp_word);
                    check("rise_edges", rise_cnt, W);
`ifdef SPI_MASTER_RX_EN
                    check("rx_valid_at_end", rx_valid, 1);
                    check("rx_data", rx_data, exp_word);
`endif
                end
            end
`ifdef SPI_MASTER_RX_EN
            else if (rx_valid) begin
                check("rx_valid_stray", rx_valid, 0);
            end
`endif
            if (cs_n) hi_cnt++;
            else hi_cnt = 0;
            prev_sclk = sclk;
            prev_cs_n = cs_n;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", ready, 1);
    endtask

    // Upstream timing: valid is a one-cycle pulse two cycles after ready was sampled.
    task automatic send(input logic [W-1:0] w);
        @(posedge clk);
        #1;
        wait_ready();
        repeat (2) @(posedge clk);
        #1;
        valid = 1'b1;
        data  = w;
        sb_q.push_back(w);
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = W'($urandom);
    endtask

    task automatic ignored_pulse(input int delay);
        repeat (delay) @(posedge clk);
        #1;
        check("ready_low_when_busy", ready, 0);
        check("busy_high", busy, 1);
        valid = 1'b1;
        data  = '0;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || !ready) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic   ps;
        int     rises;
        int     n;

        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", ready, 1);
        check("busy_after_release", busy, 0);

        send(8'hA5);
        send(8'h3C);
        send(8'hFF);

        send(8'h96);
        ignored_pulse(3);
        drain();

        // Abort mid-SHIFT after three rising edges.
        send(8'hC3);
        rises = 0;
        n     = 0;
        ps    = sclk;
        while (rises < 3 && n < 500) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk;
            n++;
        end
        check("abort_reached_3_bits", rises, 3);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_ready", ready, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_abort", ready, 1);
        send(8'h81);
        drain();

        for (int i = 0; i < 12; i++) begin
            send(W'($urandom));
            if ($urandom_range(0, 2) == 0) ignored_pulse($urandom_range(0, READY_LOW - 4));
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        drain();

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI master serializer, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits directly downstream of the FIFO-to-SPI TX control stage.
- Accepts one word per valid/ready handshake and drives cs_n, sclk and mosi to the chip under test.
- Reports tx_ready back upstream so the control stage knows when to fetch the next FIFO word.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; must match the upstream FIFO width.
- CLK_DIV, 4, system clocks per SCLK half-period; legal range is 1 or more.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spi_tx_data_valid  input  1  word valid from upstream; may be a single-cycle pulse
- spi_tx_data  input  DATA_WIDTH  word to transmit, sampled only on accept
- spi_tx_ready  output  1  high when a word can be accepted this cycle
- spi_busy  output  1  high while a transaction is in progress (inverse of ready after reset)
- spi_cs_n  output  1  chip select, active low
- spi_sclk  output  1  serial clock, idles low
- spi_mosi  output  1  serial data out

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, spi_tx_ready=0, spi_busy=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, shift register and counters cleared.
  - spi_tx_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-transaction aborts immediately: cs_n returns to 1 and sclk to 0 with no glitch beyond the reset edge, and the word is lost.
- All outputs are registered.
- Accept condition: spi_tx_data_valid && spi_tx_ready on the same clk edge.
  - spi_tx_ready stays high in IDLE until a word is accepted; it never drops without an accept. This is required because upstream issues valid as a one-cycle pulse two cycles after sampling ready.
  - Valid while not ready is ignored: no capture, no state change.
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
  - IDLE: cs_n=1, sclk=0, ready=1. On accept: load shift register, drive mosi=data[DATA_WIDTH-1], cs_n=0, ready=0, busy=1, go to CS_SETUP.
  - CS_SETUP: one half-period (CLK_DIV cycles), sclk=0, MSB stable on mosi. Then go to SHIFT.
  - SHIFT: 2*DATA_WIDTH half-periods, each CLK_DIV cycles.
    - sclk toggles at each half-period boundary: first toggle is rising.
    - On each falling edge, the shift register shifts left and mosi takes the next bit.
    - After the DATA_WIDTH-th falling edge, sclk=0; go to CS_HOLD.
  - CS_HOLD: one half-period, cs_n=0, sclk=0, mosi holds the LSB. Then return to IDLE with cs_n=1, ready=1, busy=0 in the same cycle.
- Timing:
  - Exactly DATA_WIDTH rising sclk edges per transaction.
  - ready is low for exactly (2*DATA_WIDTH+2)*CLK_DIV cycles after the accept edge. For DATA_WIDTH=8, CLK_DIV=2 this is 36 cycles.
  - Back-to-back words: cs_n is high for at least 1 cycle between transactions.
- Arithmetic:
  - Divider counter width is $clog2(CLK_DIV+1) and wraps at CLK_DIV-1.
  - Bit counter width is $clog2(2*DATA_WIDTH+1).
  - CLK_DIV=1 must work: sclk toggles every clk.

Optional Feature:
- Macro: SPI_MASTER_RX_EN.
- Defined (full duplex):
  - Adds ports spi_miso (input, 1), spi_rx_data (output, DATA_WIDTH) and spi_rx_data_valid (output, 1).
  - MISO is sampled on every rising sclk edge into an rx shift register, MSB first.
  - spi_rx_data is updated and spi_rx_data_valid pulses for 1 cycle on the CS_HOLD -> IDLE transition.
  - Reset values: spi_rx_data=0, spi_rx_data_valid=0.
- Undefined: the ports and logic are absent; TX behaviour is identical in both builds.

Decomposition:
- Shared package spi_pkg:
  - FSM state encodings (IDLE=0, CS_SETUP=1, SHIFT=2, CS_HOLD=3, 2 bits).
  - SPI mode constants (CPOL=0, CPHA=0).
  - Default DATA_WIDTH and CLK_DIV.
- One natural sub-module, spi_clk_div:
  - Enable-gated CLK_DIV counter emitting a 1-cycle half_tick at each half-period boundary.
  - Cleared when the FSM is in IDLE.

Test Plan:
- Reset release, DATA_WIDTH=8, CLK_DIV=2 -> cs_n=1, sclk=0, mosi=0, ready=0 during reset; ready=1 on first edge after release.
- 1-cycle valid with data 0xA5 -> mosi bits 1,0,1,0,0,1,0,1 sampled on 8 sclk rising edges; ready low for 36 cycles; cs_n low spanning all edges.
- Two words 0x3C then 0xFF driven through the upstream control stage timing (valid 2 cycles after ready) -> both transmitted, no word dropped, cs_n high at least 1 cycle between them.
- Valid pulse while busy with 0x00 -> ignored; in-flight word unchanged; exactly 8 rising edges.
- rst_n asserted mid-SHIFT after 3 bits -> cs_n=1, sclk=0 asynchronously; next accepted word 0x81 transmits cleanly.
- SPI_MASTER_RX_EN defined, CLK_DIV=1, miso looped to mosi with 0x5A -> spi_rx_data=0x5A and spi_rx_data_valid high for 1 cycle when ready returns.
